// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-wide, registered-read data memory.
// Optional macro LSU_MISALIGN_CHECK_EN turns misaligned H/W accesses into errors.
module load_store_unit #(
    parameter int MEM_WORDS = 100001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;

    state_t      state;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;

    logic        accept;
    logic        f3_bad;
    logic        oob;
    logic        err;
    logic [1:0]  off;
    logic [4:0]  sh;
    logic [31:0] shifted;
    logic [31:0] ext;
    logic [31:0] mask;
    logic [31:0] merged;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;

    always_comb begin
        f3_bad = 1'b1;
        unique case (req_funct3)
            3'b000, 3'b001, 3'b010: f3_bad = 1'b0;
            3'b100, 3'b101:         f3_bad = req_we;
            default:                f3_bad = 1'b1;
        endcase
        oob = {2'b00, req_addr[31:2]} >= 32'(MEM_WORDS);
        // Aligned offset; a misaligned access is one whose raw offset differs.
        off = req_addr[1:0];
        unique case (req_funct3[1:0])
            2'b01:   off = {req_addr[1], 1'b0};
            2'b10:   off = 2'b00;
            default: off = req_addr[1:0];
        endcase
`ifdef LSU_MISALIGN_CHECK_EN
        err = f3_bad || oob || (off != req_addr[1:0]);
`else
        err = f3_bad || oob;
`endif
    end

    always_comb begin
        sh      = {off_q, 3'b000};
        shifted = mem_rdata >> sh;
        unique case (f3_q)
            3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  ext = {24'h0, shifted[7:0]};
            3'b101:  ext = {16'h0, shifted[15:0]};
            default: ext = mem_rdata;
        endcase
        mask   = (f3_q[1:0] == 2'b00) ? 32'h0000_00ff : 32'h0000_ffff;
        mask   = mask << sh;
        merged = (mem_rdata & ~mask) | ((wdata_q << sh) & mask);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'h0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            we_q      <= 1'b0;
            f3_q      <= 3'b000;
            off_q     <= 2'b00;
            wdata_q   <= 32'h0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'h0;
            mem_we    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        off_q   <= off;
                        wdata_q <= req_wdata;
                        if (err) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else begin
                            mem_addr <= {2'b00, req_addr[31:2]};
                            if (req_we && req_funct3[1:0] == 2'b10) begin
                                mem_wdata <= req_wdata;
                                mem_we    <= 1'b1;
                                state     <= WR;
                            end else begin
                                state <= RD;
                            end
                        end
                    end
                end
                RD: state <= CAP;
                CAP: begin
                    // Sub-word stores come through here for the read half of RMW.
                    if (we_q) begin
                        mem_wdata <= merged;
                        mem_we    <= 1'b1;
                        state     <= WR;
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= ext;
                        state     <= IDLE;
                    end
                end
                WR: begin
                    rsp_valid <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table, hand sequences
// and randomized traffic against a byte-level reference memory.
module tb_load_store_unit;

    localparam int MEM_WORDS = 100001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_funct3(req_funct3),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    logic [31:0] dmem [int unsigned];
    logic [31:0] ref_mem [int unsigned];
    int          we_cnt = 0;
    logic [31:0] last_waddr = 32'h0;
    logic [31:0] last_wdata = 32'h0;

    // Registered-read data memory with whole-word writes
    always @(posedge clk) begin
        mem_rdata <= dmem.exists(mem_addr) ? dmem[mem_addr] : 32'h0;
        if (mem_we) begin
            we_cnt     <= we_cnt + 1;
            last_waddr <= mem_addr;
            last_wdata <= mem_wdata;
            dmem[mem_addr] = mem_wdata;
        end
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_rd(input int unsigned i);
        return ref_mem.exists(i) ? ref_mem[i] : 32'h0;
    endfunction

    // Reference: byte-lane arithmetic on a word array
    task automatic ref_op(input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic err, output logic [31:0] rd,
                          output int lat, output int nwe);
        int unsigned idx, nb, o;
        logic [31:0] m, w;
        err = 1'b0; rd = 32'h0; lat = 1; nwe = 0;
        if (f3 == 3 || f3 >= 6 || (we && f3 >= 4)) err = 1'b1;
        idx = a / 4;
        if (idx >= MEM_WORDS) err = 1'b1;
        nb = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        o = a % 4;
        if (o % nb != 0) begin
`ifdef LSU_MISALIGN_CHECK_EN
            err = 1'b1;
`else
            o = o - (o % nb);
`endif
        end
        if (err) return;
        m = (nb == 1) ? 32'hFF : (nb == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
        w = ref_rd(idx);
        if (!we) begin
            rd = (w >> (8 * o)) & m;
            if (!f3[2] && nb < 4 && rd[8*nb-1]) rd = rd | ~m;
            lat = 3;
        end else begin
            ref_mem[idx] = (w & ~(m << (8 * o))) | ((wd & m) << (8 * o));
            nwe = 1;
            lat = (nb == 4) ? 2 : 4;
        end
    endtask

    task automatic xact(input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic err, output logic [31:0] rd,
                        output int lat, output int nwe);
        int w0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3;
        req_addr = a; req_wdata = wd;
        w0 = we_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = -1; err = 1'bx; rd = 32'hx;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = i; err = rsp_err; rd = rsp_rdata;
                break;
            end
        end
        nwe = we_cnt - w0;
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic        e_err, a_err;
        logic [31:0] e_rd, a_rd;
        int          e_lat, a_lat, e_nwe, a_nwe, w0;

        #12;
        chk("rst_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        @(negedge clk);
        rst_n = 1'b1;

        dmem[4] = 32'h8899AABB;
        ref_mem[4] = 32'h8899AABB;

        tbl.push_back('{1'b0, 3'b010, 32'h10, 32'h0, 32'h8899AABB, 1'b0, 3});
        tbl.push_back('{1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF88, 1'b0, 3});
        tbl.push_back('{1'b0, 3'b100, 32'h13, 32'h0, 32'h00000088, 1'b0, 3});
        tbl.push_back('{1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF8899, 1'b0, 3});
        tbl.push_back('{1'b0, 3'b101, 32'h10, 32'h0, 32'h0000AABB, 1'b0, 3});
        tbl.push_back('{1'b1, 3'b001, 32'h16, 32'h1234CAFE, 32'h0, 1'b0, 4});
        tbl.push_back('{1'b0, 3'b010, 32'h14, 32'h0, 32'hCAFE0000, 1'b0, 3});
        tbl.push_back('{1'b0, 3'b000, 32'h16, 32'h0, 32'hFFFFFFFE, 1'b0, 3});
        tbl.push_back('{1'b1, 3'b000, 32'h11, 32'h12345677, 32'h0, 1'b0, 4});
        tbl.push_back('{1'b0, 3'b010, 32'h10, 32'h0, 32'h889977BB, 1'b0, 3});
        tbl.push_back('{1'b1, 3'b100, 32'h10, 32'h55, 32'h0, 1'b1, 1});
        tbl.push_back('{1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1});
        tbl.push_back('{1'b0, 3'b111, 32'h10, 32'h0, 32'h0, 1'b1, 1});
        tbl.push_back('{1'b0, 3'b010, 32'h00061A84, 32'h0, 32'h0, 1'b1, 1});
        tbl.push_back('{1'b1, 3'b010, 32'h00061A84, 32'h1, 32'h0, 1'b1, 1});
        tbl.push_back('{1'b0, 3'b010, 32'h00061A80, 32'h0, 32'h0, 1'b0, 3});

        foreach (tbl[i]) begin
            ref_op(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata,
                   e_err, e_rd, e_lat, e_nwe);
            xact(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata,
                 a_err, a_rd, a_lat, a_nwe);
            chk($sformatf("vec%0d_rdata", i), a_rd, tbl[i].rdata);
            chk($sformatf("vec%0d_err", i), a_err, tbl[i].err);
            chk($sformatf("vec%0d_lat", i), a_lat, tbl[i].lat);
            chk($sformatf("vec%0d_nwe", i), a_nwe,
                (tbl[i].we && !tbl[i].err) ? 1 : 0);
        end
        chk("sb_waddr", last_waddr, 32'd4);
        chk("sb_wdata", last_wdata, 32'h889977BB);

        // SW with a load held behind it
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h20; req_wdata = 32'hDEADBEEF;
        w0 = we_cnt;
        @(posedge clk);
        #1 req_we = 1'b0; req_wdata = 32'h0;
        @(negedge clk);
        chk("busy_ready", req_ready, 0);
        @(negedge clk);
        chk("sw_rsp_valid", rsp_valid, 1);
        chk("rsp_cycle_ready", req_ready, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        a_lat = -1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                a_lat = i; a_rd = rsp_rdata; a_err = rsp_err;
                break;
            end
        end
        chk("held_lw_lat", a_lat, 3);
        chk("held_lw_rdata", a_rd, 32'hDEADBEEF);
        chk("held_lw_err", a_err, 0);
        chk("sw_nwe", we_cnt - w0, 1);
        ref_op(1'b1, 3'b010, 32'h20, 32'hDEADBEEF, e_err, e_rd, e_lat, e_nwe);

        // Misaligned word load
        xact(1'b0, 3'b010, 32'h22, 32'h0, a_err, a_rd, a_lat, a_nwe);
`ifdef LSU_MISALIGN_CHECK_EN
        chk("mis_lw_err", a_err, 1);
        chk("mis_lw_rdata", a_rd, 32'h0);
        chk("mis_lw_lat", a_lat, 1);
`else
        chk("mis_lw_err", a_err, 0);
        chk("mis_lw_rdata", a_rd, 32'hDEADBEEF);
        chk("mis_lw_lat", a_lat, 3);
`endif
        chk("mis_lw_nwe", a_nwe, 0);

        // Reset while an SH sits in its write cycle
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001;
        req_addr = 32'h20; req_wdata = 32'h1234;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("sh_wr_we", mem_we, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_we_async", mem_we, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_word", dmem[8], 32'hDEADBEEF);
        chk("abort_ready", req_ready, 1);
        chk("abort_rsp_valid", rsp_valid, 0);

        for (int n = 0; n < 300; n++) begin
            logic        we;
            logic [2:0]  f3;
            logic [31:0] a, wd;
            we = 1'($urandom % 2);
            f3 = 3'($urandom % 8);
            a  = ($urandom % 16 == 0) ? $urandom : 32'($urandom_range(0, 63));
            wd = $urandom;
            ref_op(we, f3, a, wd, e_err, e_rd, e_lat, e_nwe);
            xact(we, f3, a, wd, a_err, a_rd, a_lat, a_nwe);
            chk($sformatf("rnd%0d_rdata", n), a_rd, e_rd);
            chk($sformatf("rnd%0d_err", n), a_err, e_err);
            chk($sformatf("rnd%0d_lat", n), a_lat, e_lat);
            chk($sformatf("rnd%0d_nwe", n), a_nwe, e_nwe);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
